uart_rx_packetizer: RTL and testbench
=====================================

// Module: uart_rx_packetizer
// PURPOSE
//   Frame controller behind uart_rx. Consumes its per-byte ready/error/data strobes and assembles packets:
//   SYNC, LEN, LEN payload bytes, CHK (XOR of LEN and all payload bytes).
//   Holds one validated packet in an internal buffer for a downstream consumer.
//   Reports framing, parity, length, checksum and timeout faults.
// PARAMETERS
//   SYSCLK_FREQUENCY_HZ  `SYSCLK_FREQUENCY_HZ  system clock, Hz
//   BAUDRATE             `BAUDRATE             line rate; sets the timeout base
//   DATA_LENGTH          `DATA_LENGTH          bits per UART byte (8)
//   SYNC_BYTE            8'hA5                 frame start marker
//   MAX_PAYLOAD          16                    max payload bytes; 1 <= MAX_PAYLOAD <= 2**DATA_LENGTH-1
//   TIMEOUT_SYMBOLS      20                    max gap between bytes inside a frame, in symbol times
// PORTS
//   sysclk       in   1                 system clock, all logic on posedge
//   rst          in   1                 synchronous, active-high reset
//   rx_ready     in   1                 1-cycle byte strobe from uart_rx
//   rx_error     in   1                 parity error flag, valid with rx_ready
//   rx_data      in   DATA_LENGTH       received byte, valid with rx_ready
//   pkt_valid    out  1                 validated packet held in buffer
//   pkt_len      out  LEN_W             payload length, valid while pkt_valid; LEN_W=$clog2(MAX_PAYLOAD+1)
//   rd_addr      in   $clog2(MAX_PAYLOAD) buffer read index
//   rd_data      out  DATA_LENGTH       buffer[rd_addr], registered, 1-cycle read latency
//   pkt_ack      in   1                 consumer releases buffer
//   err_pulse    out  1                 1-cycle fault strobe
//   err_code     out  2                 0 parity, 1 length, 2 checksum, 3 timeout; valid with err_pulse
//   overrun_cnt  out  8                 bytes dropped while in HOLD, saturates at 255
//   busy         out  1                 state is LEN, PAYLOAD or CHECK
// BEHAVIOUR
//   Reset: state HUNT; outputs pkt_valid, pkt_len, rd_data, err_pulse, err_code, overrun_cnt and busy all 0.
//     Reset clears the buffer-valid flag only; buffer contents are don't-care.
//   FSM is evaluated only on rx_ready cycles, except timeout and ack. States:
//   HUNT: byte == SYNC_BYTE with !rx_error -> LEN. Any other byte is dropped silently, no error.
//   LEN: rx_error -> err parity, HUNT.
//     LEN == 0 or LEN > MAX_PAYLOAD -> err length, HUNT.
//     Otherwise: latch LEN, chk = LEN, idx = 0, -> PAYLOAD.
//   PAYLOAD: rx_error -> err parity, HUNT.
//     Otherwise: buf[idx] = byte, chk ^= byte, idx++.
//     Byte number LEN -> CHECK.
//   CHECK: rx_error -> err parity, HUNT.
//     byte != chk -> err checksum, HUNT.
//     byte == chk -> HOLD; pkt_valid rises on the cycle after the CHK strobe.
//   HOLD: pkt_valid = 1, pkt_len stable, buffer frozen.
//     pkt_ack -> pkt_valid = 0 next cycle, -> HUNT.
//     rx_ready without pkt_ack -> byte dropped, overrun_cnt++ (saturating at 255).
//     rx_ready with pkt_ack in the same cycle -> byte is evaluated as a HUNT byte; not counted as overrun.
//   Timeout: counter cleared on every rx_ready and on entry to LEN.
//     Counter increments each cycle in LEN, PAYLOAD and CHECK.
//     Reaching TIMEOUT_SYMBOLS*(SYSCLK_FREQUENCY_HZ/BAUDRATE)-1 -> err timeout, HUNT.
//     rx_ready in the same cycle as expiry: the byte wins; no timeout is raised.
//   Timing: err_pulse is registered, asserted the cycle after the offending strobe or expiry.
//     Aborts discard the partial frame; a held packet is never touched by a later abort.
//   pkt_ack outside HOLD: ignored.
//   rd_addr >= pkt_len: rd_data is don't-care.
//   Arithmetic: chk is DATA_LENGTH bits, plain XOR. idx width $clog2(MAX_PAYLOAD+1); it never wraps because of the LEN bound.
//   Reset mid-frame or in HOLD: immediately back to HUNT; the held packet is lost.
// TESTING
//   A5 03 11 22 33 03 (chk = 03^11^22^33 = 03) -> pkt_valid=1, pkt_len=3; rd 0..2 = 11,22,33; ack -> pkt_valid=0 next cycle.
//   A5 00 / A5 11 (MAX_PAYLOAD=16) -> err_pulse with err_code=1 each time; back in HUNT; next good frame accepted.
//   A5 02 10 20 00 (expected chk 32) -> err_code=2, no pkt_valid.
//   A5 02 10, then idle > timeout -> err_code=3 exactly once; busy=0 afterwards.
//   In HOLD, 3 bytes without ack -> overrun_cnt=3, buffer unchanged.
//     SYNC byte in the same cycle as ack -> next frame received without loss.
//   Byte with rx_error in PAYLOAD -> err_code=0.
//     rst asserted mid-PAYLOAD -> all outputs 0 next cycle; a following clean frame passes.

Source files
------------

// File: rtl/uart_rx_packetizer.sv
// Purpose    : frames uart_rx byte strobes into SYNC/LEN/payload/CHK packets and holds one validated packet.
// Latency    : pkt_valid and err_pulse follow the causing strobe by one cycle; rd_data is one cycle behind rd_addr.
// Backpressure: none on the byte side; bytes arriving while a packet is held are dropped and counted in overrun_cnt.
//
// Ports:
//   sysclk, rst                 clock and synchronous active-high reset
//   rx_ready/rx_error/rx_data   per-byte strobe, parity flag and byte from uart_rx
//   pkt_valid/pkt_len           held packet present and its payload length
//   rd_addr/rd_data             registered read port into the held payload
//   pkt_ack                     consumer releases the held packet
//   err_pulse/err_code          fault strobe: 0 parity, 1 length, 2 checksum, 3 timeout
//   overrun_cnt                 saturating count of bytes dropped while holding
//   busy                        a frame is being assembled
module uart_rx_packetizer #(
  parameter int                     SYSCLK_FREQUENCY_HZ = 50_000_000,
  parameter int                     BAUDRATE            = 115_200,
  parameter int                     DATA_LENGTH         = 8,
  parameter logic [DATA_LENGTH-1:0] SYNC_BYTE           = 8'hA5,
  parameter int                     MAX_PAYLOAD         = 16,
  parameter int                     TIMEOUT_SYMBOLS     = 20,
  localparam int                    LEN_W               = $clog2(MAX_PAYLOAD + 1),
  localparam int                    ADDR_W              = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1
) (
  input  logic                   sysclk,
  input  logic                   rst,
  input  logic                   rx_ready,
  input  logic                   rx_error,
  input  logic [DATA_LENGTH-1:0] rx_data,
  output logic                   pkt_valid,
  output logic [LEN_W-1:0]       pkt_len,
  input  logic [ADDR_W-1:0]      rd_addr,
  output logic [DATA_LENGTH-1:0] rd_data,
  input  logic                   pkt_ack,
  output logic                   err_pulse,
  output logic [1:0]             err_code,
  output logic [7:0]             overrun_cnt,
  output logic                   busy
);

  localparam int TO_MAX = TIMEOUT_SYMBOLS * (SYSCLK_FREQUENCY_HZ / BAUDRATE) - 1;
  localparam int TO_W   = $clog2(TO_MAX + 1);
  // The counter reaches TO_MAX on the idle cycle where it currently holds TO_MAX-1.
  localparam logic [TO_W-1:0]        TO_FIRE = TO_W'(TO_MAX - 1);
  localparam logic [DATA_LENGTH-1:0] MAX_LEN = DATA_LENGTH'(MAX_PAYLOAD);

  localparam logic [1:0] ERR_PARITY   = 2'd0;
  localparam logic [1:0] ERR_LENGTH   = 2'd1;
  localparam logic [1:0] ERR_CHECKSUM = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  localparam logic [2:0] HUNT    = 3'd0;
  localparam logic [2:0] LEN     = 3'd1;
  localparam logic [2:0] PAYLOAD = 3'd2;
  localparam logic [2:0] CHECK   = 3'd3;
  localparam logic [2:0] HOLD    = 3'd4;

  logic [2:0]             state;
  logic [LEN_W-1:0]       len_q;
  logic [LEN_W-1:0]       idx;
  logic [LEN_W-1:0]       idx_nxt;
  logic [DATA_LENGTH-1:0] chk;
  logic [TO_W-1:0]        tcnt;
  logic                   is_sync;
  logic [DATA_LENGTH-1:0] pkt_mem [MAX_PAYLOAD];

  assign idx_nxt = idx + 1'b1;
  assign is_sync = rx_ready && !rx_error && (rx_data == SYNC_BYTE);
  assign busy    = (state == LEN) || (state == PAYLOAD) || (state == CHECK);

  // Payload storage carries no reset; only PAYLOAD writes it, so a held packet stays frozen.
  always_ff @(posedge sysclk) begin
    if (!rst && state == PAYLOAD && rx_ready && !rx_error) begin
      pkt_mem[idx[ADDR_W-1:0]] <= rx_data;
    end
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= pkt_mem[rd_addr];
    end
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state       <= HUNT;
      pkt_valid   <= 1'b0;
      pkt_len     <= '0;
      err_pulse   <= 1'b0;
      err_code    <= ERR_PARITY;
      overrun_cnt <= '0;
      len_q       <= '0;
      idx         <= '0;
      chk         <= '0;
      tcnt        <= '0;
    end else begin
      err_pulse <= 1'b0;

      // Gap timer only runs between bytes of a frame in progress.
      if (rx_ready || !busy) begin
        tcnt <= '0;
      end else begin
        tcnt <= tcnt + 1'b1;
      end

      case (state)
        HUNT: begin
          if (is_sync) state <= LEN;
        end
        LEN: begin
          if (rx_ready) begin
            if (rx_error) begin
              err_pulse <= 1'b1;
              err_code  <= ERR_PARITY;
              state     <= HUNT;
            end else if (rx_data == '0 || rx_data > MAX_LEN) begin
              err_pulse <= 1'b1;
              err_code  <= ERR_LENGTH;
              state     <= HUNT;
            end else begin
              len_q <= rx_data[LEN_W-1:0];
              chk   <= rx_data;
              idx   <= '0;
              state <= PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          if (rx_ready) begin
            if (rx_error) begin
              err_pulse <= 1'b1;
              err_code  <= ERR_PARITY;
              state     <= HUNT;
            end else begin
              chk <= chk ^ rx_data;
              idx <= idx_nxt;
              if (idx_nxt == len_q) state <= CHECK;
            end
          end
        end
        CHECK: begin
          if (rx_ready) begin
            if (rx_error) begin
              err_pulse <= 1'b1;
              err_code  <= ERR_PARITY;
              state     <= HUNT;
            end else if (rx_data != chk) begin
              err_pulse <= 1'b1;
              err_code  <= ERR_CHECKSUM;
              state     <= HUNT;
            end else begin
              pkt_valid <= 1'b1;
              pkt_len   <= len_q;
              state     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (pkt_ack) begin
            // A byte arriving with the ack is treated as the first HUNT byte.
            pkt_valid <= 1'b0;
            state     <= is_sync ? LEN : HUNT;
          end else if (rx_ready && overrun_cnt != 8'hFF) begin
            overrun_cnt <= overrun_cnt + 8'd1;
          end
        end
        default: state <= HUNT;
      endcase

      // A byte in the expiry cycle takes precedence, so only idle cycles can time out.
      if (busy && !rx_ready && tcnt == TO_FIRE) begin
        err_pulse <= 1'b1;
        err_code  <= ERR_TIMEOUT;
        state     <= HUNT;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_packetizer.sv
// Bench for uart_rx_packetizer: directed vector table, hand sequences for
// multi-cycle corners, and randomized frames checked against expected outcomes.
module tb_uart_rx_packetizer;

  localparam int MAXP = 16;

  logic       sysclk = 1'b0;
  logic       rst;
  logic       rx_ready;
  logic       rx_error;
  logic [7:0] rx_data;
  logic       pkt_valid;
  logic [4:0] pkt_len;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       pkt_ack;
  logic       err_pulse;
  logic [1:0] err_code;
  logic [7:0] overrun_cnt;
  logic       busy;

  int tests = 0;
  int fails = 0;
  logic [1:0] err_q[$];

  always #5 sysclk = ~sysclk;

  uart_rx_packetizer #(
    .SYSCLK_FREQUENCY_HZ(1000),
    .BAUDRATE           (200),
    .DATA_LENGTH        (8),
    .SYNC_BYTE          (8'hA5),
    .MAX_PAYLOAD        (MAXP),
    .TIMEOUT_SYMBOLS    (20)
  ) dut (
    .sysclk     (sysclk),
    .rst        (rst),
    .rx_ready   (rx_ready),
    .rx_error   (rx_error),
    .rx_data    (rx_data),
    .pkt_valid  (pkt_valid),
    .pkt_len    (pkt_len),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .pkt_ack    (pkt_ack),
    .err_pulse  (err_pulse),
    .err_code   (err_code),
    .overrun_cnt(overrun_cnt),
    .busy       (busy)
  );

  // Every fault strobe is logged so a frame can be checked for exactly one error.
  always @(negedge sysclk) begin
    if (!rst && err_pulse) err_q.push_back(err_code);
  end

  typedef struct {
    int             nb;
    logic [5:0][7:0] b;
    int             err_at;
    int             exp_err;
    int             exp_len;
    int             pl_at;
  } vec_t;

  function automatic vec_t mkv(input int nb, input logic [7:0] b0, b1, b2, b3, b4, b5,
                               input int err_at, exp_err, exp_len, pl_at);
    vec_t v;
    v.nb = nb;
    v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3; v.b[4] = b4; v.b[5] = b5;
    v.err_at = err_at; v.exp_err = exp_err; v.exp_len = exp_len; v.pl_at = pl_at;
    return v;
  endfunction

  task automatic tick;
    @(posedge sysclk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic e, input logic ack);
    rx_data  = b;
    rx_error = e;
    rx_ready = 1'b1;
    pkt_ack  = ack;
    tick;
    rx_ready = 1'b0;
    rx_error = 1'b0;
    pkt_ack  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] fb[$], input int err_pos, input int max_gap);
    for (int i = 0; i < fb.size(); i++) begin
      repeat ($urandom_range(max_gap, 0)) tick;
      send_byte(fb[i], (i == err_pos), 1'b0);
    end
  endtask

  task automatic read_chk(input string tag, input int addr, input logic [7:0] exp);
    rd_addr = 4'(addr);
    tick;
    chk(tag, rd_data, exp);
  endtask

  // Idle past the timeout window, then check errors seen and the held packet.
  task automatic check_outcome(input string tag, input int exp_err, input logic [7:0] pl[$]);
    repeat (130) tick;
    chk({tag, " err count"}, err_q.size(), (exp_err < 0) ? 0 : 1);
    if (exp_err >= 0 && err_q.size() > 0) chk({tag, " err code"}, err_q[0], exp_err);
    chk({tag, " busy idle"}, busy, 0);
    chk({tag, " pkt_valid"}, pkt_valid, (pl.size() > 0) ? 1 : 0);
    if (pl.size() > 0) begin
      chk({tag, " pkt_len"}, pkt_len, pl.size());
      for (int i = 0; i < pl.size(); i++) read_chk({tag, " rd_data"}, i, pl[i]);
    end
    if (pkt_valid) begin
      pkt_ack = 1'b1;
      tick;
      pkt_ack = 1'b0;
      chk({tag, " pkt_valid after ack"}, pkt_valid, 0);
    end
    err_q.delete();
  endtask

  vec_t vecs[11];

  initial begin
    logic [7:0] fq[$];
    logic [7:0] pl[$];

    vecs[0]  = mkv(6, 8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03, -1, -1, 3, 2);
    vecs[1]  = mkv(2, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, -1,  1, 0, 0);
    vecs[2]  = mkv(2, 8'hA5, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, -1,  1, 0, 0);
    vecs[3]  = mkv(5, 8'hA5, 8'h02, 8'h10, 8'h20, 8'h00, 8'h00, -1,  2, 0, 0);
    vecs[4]  = mkv(3, 8'hA5, 8'h02, 8'h10, 8'h00, 8'h00, 8'h00, -1,  3, 0, 0);
    vecs[5]  = mkv(4, 8'hA5, 8'h02, 8'h10, 8'h20, 8'h00, 8'h00,  3,  0, 0, 0);
    vecs[6]  = mkv(6, 8'h11, 8'h22, 8'hA5, 8'h01, 8'h7E, 8'h7F, -1, -1, 1, 4);
    vecs[7]  = mkv(4, 8'hA5, 8'h01, 8'h7E, 8'h7F, 8'h00, 8'h00,  0, -1, 0, 0);
    vecs[8]  = mkv(2, 8'hA5, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00,  1,  0, 0, 0);
    vecs[9]  = mkv(4, 8'hA5, 8'h01, 8'hA5, 8'hA4, 8'h00, 8'h00, -1, -1, 1, 2);
    vecs[10] = mkv(5, 8'hA5, 8'h02, 8'h10, 8'h20, 8'h32, 8'h00, -1, -1, 2, 2);

    rst = 1'b1; rx_ready = 1'b0; rx_error = 1'b0; rx_data = '0; pkt_ack = 1'b0; rd_addr = '0;
    repeat (3) tick;
    rst = 1'b0;
    chk("reset pkt_valid", pkt_valid, 0);
    chk("reset pkt_len", pkt_len, 0);
    chk("reset rd_data", rd_data, 0);
    chk("reset err_pulse", err_pulse, 0);
    chk("reset err_code", err_code, 0);
    chk("reset overrun_cnt", overrun_cnt, 0);
    chk("reset busy", busy, 0);

    // Overrun while holding, then a SYNC byte coinciding with the ack.
    fq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    send_frame(fq, -1, 2);
    chk("hold pkt_valid rises", pkt_valid, 1);
    send_byte(8'hA5, 1'b0, 1'b0);
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'hFF, 1'b0, 1'b0);
    chk("overrun_cnt", overrun_cnt, 3);
    chk("hold pkt_valid kept", pkt_valid, 1);
    chk("hold pkt_len kept", pkt_len, 3);
    read_chk("hold buf0", 0, 8'h11);
    read_chk("hold buf1", 1, 8'h22);
    read_chk("hold buf2", 2, 8'h33);
    send_byte(8'hA5, 1'b0, 1'b1);
    chk("ack+sync pkt_valid", pkt_valid, 0);
    chk("ack+sync busy", busy, 1);
    chk("ack+sync overrun", overrun_cnt, 3);
    fq = '{8'h01, 8'h7E, 8'h7F};
    send_frame(fq, -1, 2);
    pl = '{8'h7E};
    check_outcome("ack+sync frame", -1, pl);

    // err_pulse lasts exactly the cycle after the offending strobe.
    send_byte(8'hA5, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    chk("len err pulse", err_pulse, 1);
    chk("len err code", err_code, 1);
    tick;
    chk("len err pulse width", err_pulse, 0);
    err_q.delete();

    // A gap just under the timeout window must not abort the frame.
    send_byte(8'hA5, 1'b0, 1'b0);
    send_byte(8'h01, 1'b0, 1'b0);
    repeat (90) tick;
    send_byte(8'h7E, 1'b0, 1'b0);
    send_byte(8'h7F, 1'b0, 1'b0);
    pl = '{8'h7E};
    check_outcome("long gap", -1, pl);

    for (int v = 0; v < 11; v++) begin
      fq = {};
      pl = {};
      for (int i = 0; i < vecs[v].nb; i++) fq.push_back(vecs[v].b[i]);
      for (int i = 0; i < vecs[v].exp_len; i++) pl.push_back(vecs[v].b[vecs[v].pl_at + i]);
      send_frame(fq, vecs[v].err_at, 3);
      check_outcome($sformatf("vec%0d", v), vecs[v].exp_err, pl);
    end

    // Reset in the middle of a payload.
    fq = '{8'hA5, 8'h04, 8'h01, 8'h02};
    send_frame(fq, -1, 1);
    chk("mid-frame busy", busy, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rst busy", busy, 0);
    chk("rst pkt_valid", pkt_valid, 0);
    chk("rst err_code", err_code, 0);
    chk("rst overrun_cnt", overrun_cnt, 0);
    chk("rst rd_data", rd_data, 0);
    fq = '{8'hA5, 8'h02, 8'hC3, 8'h3C, 8'hFD};
    send_frame(fq, -1, 2);
    pl = '{8'hC3, 8'h3C};
    check_outcome("after rst", -1, pl);

    // Random frames; the expected outcome follows from how each frame was built.
    for (int n = 0; n < 40; n++) begin
      int kind, len, pre, ep, exp_err;
      logic [7:0] c, g;
      logic [7:0] payload[$];
      fq = {}; pl = {}; payload = {};
      ep = -1; exp_err = -1;
      pre = $urandom_range(2, 0);
      for (int i = 0; i < pre; i++) begin
        g = 8'($urandom);
        if (g == 8'hA5) g = 8'h5A;
        fq.push_back(g);
      end
      kind = $urandom_range(4, 0);
      len = $urandom_range(MAXP, 1);
      c = 8'(len);
      for (int i = 0; i < len; i++) begin
        g = 8'($urandom);
        payload.push_back(g);
        c = c ^ g;
      end
      fq.push_back(8'hA5);
      if (kind == 2) begin
        fq.push_back(($urandom_range(1, 0) == 1) ? 8'h00 : 8'($urandom_range(255, MAXP + 1)));
        exp_err = 1;
      end else begin
        fq.push_back(8'(len));
        for (int i = 0; i < len; i++) fq.push_back(payload[i]);
        if (kind == 1) begin
          fq.push_back(c ^ 8'($urandom_range(255, 1)));
          exp_err = 2;
        end else begin
          fq.push_back(c);
        end
        if (kind == 0) pl = payload;
        if (kind == 3) begin
          ep = pre + $urandom_range(len + 1, 1);
          while (fq.size() > ep + 1) void'(fq.pop_back());
          exp_err = 0;
        end
        if (kind == 4) begin
          int keep;
          keep = pre + 1 + $urandom_range(len, 1);
          while (fq.size() > keep) void'(fq.pop_back());
          exp_err = 3;
        end
      end
      send_frame(fq, ep, 20);
      check_outcome($sformatf("rand%0d kind%0d", n, kind), exp_err, pl);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

endmodule
